// File: rtl/sc_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_display_pkg
// Description : Shared definitions for the memory-mapped seven-segment
//               display driver: FSM states, active-high glyphs, the display
//               address and a nibble-to-glyph lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_display_pkg;

    // Controller-side FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Active-high glyphs, bit order g..a (bit0 = segment a)
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Address decoded by the data-memory controller for this device
    localparam logic [31:0] DISP_ADDR = 32'h8000_000C;

    // Nibble to active-high glyph (0-9, A, b, C, d, E, F)
    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_seg7_encode.sv
`default_nettype none
// ============================================================================
// Module      : sc_seg7_encode
// Description : Combinational nibble to seven-segment glyph with blanking and
//               selectable output polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_seg7_encode
    import sc_display_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    logic [6:0] w_glyph;

    // Pick the glyph (or all-off) then apply board polarity
    always_comb begin
        w_glyph = i_blank ? SEG_BLANK : seg_glyph(i_nibble);
        o_seg   = (SEG_ACTIVE_LOW != 0) ? ~w_glyph : w_glyph;
    end

endmodule
`default_nettype wire

// File: rtl/sc_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : sc_display_driver
// Description : Memory-mapped display device. Captures a CPU word and shows
//               it as raw hex or as decimal (sequential double-dabble) with
//               leading-zero blanking and overflow dashes. Writes arriving
//               during a conversion wait in a one-deep, last-write-wins slot.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_display_driver
    import sc_display_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int BIN_W          = 27,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [31:0]           wr_data,
    input  logic                  wr_hex,
    output logic                  busy,
    output logic [7*DIGITS-1:0]   hex_out
);

    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          SR_W    = BCD_W + BIN_W;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [63:0] DEC_MAX = 64'(10 ** DIGITS) - 64'd1;

    localparam logic [6:0]  POL_ZERO  = (SEG_ACTIVE_LOW != 0) ? ~SEG_0     : SEG_0;
    localparam logic [6:0]  POL_BLANK = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [6:0]  POL_MINUS = (SEG_ACTIVE_LOW != 0) ? ~SEG_MINUS : SEG_MINUS;

    state_t                 r_state;
    logic                   r_busy;
    logic [SR_W-1:0]        r_shift;      // {bcd, bin}
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_pend_valid;
    logic [31:0]            r_pend_data;
    logic                   r_pend_hex;
    logic [7*DIGITS-1:0]    r_hex_out;

    logic                   w_proc_valid;
    logic [31:0]            w_proc_data;
    logic                   w_proc_hex;
    logic                   w_ovf;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic [SR_W-1:0]        w_shift_next;
    logic [BCD_W-1:0]       w_enc_nib;
    logic [DIGITS-1:0]      w_enc_blank;
    logic [7*DIGITS-1:0]    w_enc_seg;
    logic                   w_zero_run;

    // In IDLE a parked write has priority over a fresh strobe so order is kept
    always_comb begin
        w_proc_valid = 1'b0;
        w_proc_data  = wr_data;
        w_proc_hex   = wr_hex;
        if (r_state == ST_IDLE) begin
            if (r_pend_valid) begin
                w_proc_valid = 1'b1;
                w_proc_data  = r_pend_data;
                w_proc_hex   = r_pend_hex;
            end else if (wr_en) begin
                w_proc_valid = 1'b1;
            end
        end
    end

    // Decimal overflow: bits above the conversion width, or beyond DIGITS digits
    assign w_ovf = ((w_proc_data >> BIN_W) != 32'd0) ||
                   (64'(w_proc_data[BIN_W-1:0]) > DEC_MAX);

    // Double-dabble step: per-nibble +3 correction, then shift the whole pair
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            logic [3:0] w_nib;
            assign w_nib = r_shift[BIN_W + 4*gi +: 4];
            assign w_bcd_adj[4*gi +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
        end
    endgenerate

    assign w_shift_next = {w_bcd_adj, r_shift[BIN_W-1:0]} << 1;

    // Encoder inputs: BCD digits when committing, write nibbles otherwise
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_enc_in
            if (4*gi + 3 <= 31) begin : g_hex_nib
                assign w_enc_nib[4*gi +: 4] = (r_state == ST_COMMIT) ?
                        r_shift[BIN_W + 4*gi +: 4] : w_proc_data[4*gi +: 4];
            end else begin : g_hex_pad
                assign w_enc_nib[4*gi +: 4] = (r_state == ST_COMMIT) ?
                        r_shift[BIN_W + 4*gi +: 4] : 4'h0;
            end
        end
    endgenerate

    // Leading-zero blanking from the top digit down; digit0 is never blanked
    always_comb begin
        w_enc_blank = '0;
        w_zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run     = w_zero_run & (r_shift[BIN_W + 4*i +: 4] == 4'h0);
            w_enc_blank[i] = w_zero_run & (r_state == ST_COMMIT);
        end
    end

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            sc_seg7_encode #(
                .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
            ) u_enc (
                .i_nibble (w_enc_nib[4*gi +: 4]),
                .i_blank  (w_enc_blank[gi]),
                .o_seg    (w_enc_seg[7*gi +: 7])
            );
        end
    endgenerate

    // Control FSM, pending slot and registered display outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_pend_hex   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_hex_out[7*i +: 7] <= (i == 0) ? POL_ZERO : POL_BLANK;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_proc_valid) begin
                        if (w_proc_hex) begin
                            r_hex_out <= w_enc_seg;
                        end else if (w_ovf) begin
                            for (int i = 0; i < DIGITS; i++) begin
                                r_hex_out[7*i +: 7] <= POL_MINUS;
                            end
                        end else begin
                            r_shift <= {{BCD_W{1'b0}}, w_proc_data[BIN_W-1:0]};
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_CONV;
                        end
                    end
                    // Parked entry consumed now; a simultaneous strobe takes its place
                    if (r_pend_valid) begin
                        r_pend_valid <= wr_en;
                        if (wr_en) begin
                            r_pend_data <= wr_data;
                            r_pend_hex  <= wr_hex;
                        end
                    end
                end
                ST_CONV: begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(BIN_W - 1)) begin
                        r_state <= ST_COMMIT;
                    end
                    if (wr_en) begin
                        r_pend_valid <= 1'b1;
                        r_pend_data  <= wr_data;
                        r_pend_hex   <= wr_hex;
                    end
                end
                ST_COMMIT: begin
                    r_hex_out <= w_enc_seg;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                    if (wr_en) begin
                        r_pend_valid <= 1'b1;
                        r_pend_data  <= wr_data;
                        r_pend_hex   <= wr_hex;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign hex_out = r_hex_out;

endmodule
`default_nettype wire

// File: tb/tb_sc_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_display_driver
// Description : Scoreboard bench for sc_display_driver (default parameters,
//               active-low segments).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_display_driver;

    localparam int DIGITS = 8;
    localparam int BIN_W  = 27;
    localparam int HW     = 7 * DIGITS;

    logic          clock   = 1'b0;
    logic          reset   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [31:0]   wr_data = 32'd0;
    logic          wr_hex  = 1'b0;
    logic          busy;
    logic [HW-1:0] hex_out;

    sc_display_driver #(
        .DIGITS         (DIGITS),
        .BIN_W          (BIN_W),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_hex  (wr_hex),
        .busy    (busy),
        .hex_out (hex_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Active-low glyph for a nibble
    function automatic logic [6:0] gl(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b0111111;  4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;  4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;  4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;  4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;  4'h9: g = 7'b1101111;
            4'hA: g = 7'b1110111;  4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;  4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;  default: g = 7'b1110001;
        endcase
        return ~g;
    endfunction

    function automatic logic [HW-1:0] m_dec(input int v);
        logic [HW-1:0] r;
        int d [DIGITS];
        int t;
        int msd;
        t   = v;
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = t % 10;
            t    = t / 10;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = (i > msd) ? 7'b1111111 : gl(4'(d[i]));
        end
        return r;
    endfunction

    function automatic logic [HW-1:0] m_hex(input logic [31:0] w);
        logic [HW-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[7*i +: 7] = gl(w[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [HW-1:0] m_dash();
        logic [HW-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[7*i +: 7] = 7'b0111111;
        return r;
    endfunction

    typedef struct {
        int            due;
        logic [HW-1:0] val;
    } exp_t;

    exp_t          sb [$];
    exp_t          e_mon;
    logic [HW-1:0] exp_disp;

    // Scoreboard monitor: expected update on its due cycle, otherwise hold
    always @(negedge clock) begin
        if (!reset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e_mon = sb.pop_front();
                chk("update", 64'(hex_out), 64'(e_mon.val));
                exp_disp = e_mon.val;
            end else begin
                chk("hold", 64'(hex_out), 64'(exp_disp));
            end
        end
    end

    task automatic wr(input logic [31:0] d, input logic h, input int at, output int c);
        @(posedge clock); #1;
        while (cyc < at) begin
            @(posedge clock); #1;
        end
        wr_en   = 1'b1;
        wr_data = d;
        wr_hex  = h;
        c       = cyc;
        @(posedge clock); #1;
        wr_en   = 1'b0;
        wr_data = 32'd0;
        wr_hex  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() > 0; k++) begin
            @(negedge clock); #1;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1);
    end

    int c, c0, cx, nb;

    initial begin
        exp_disp = m_dec(0);
        // Asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_hex_async", 64'(hex_out), 64'(m_dec(0)));
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_hex_rel", 64'(hex_out), 64'(m_dec(0)));

        // Decimal 1234: 29-edge latency, busy for 28 cycles
        wr(32'd1234, 1'b0, 0, c);
        sb.push_back('{due: c + BIN_W + 2, val: m_dec(1234)});
        nb = 0;
        repeat (29) begin
            @(negedge clock);
            if (busy) nb++;
        end
        chk("busy_len", 64'(nb), 64'd28);
        drain();

        // Hex write, latency 1, busy never rises
        wr(32'hDEADBEEF, 1'b1, 0, c);
        sb.push_back('{due: c + 1, val: m_hex(32'hDEADBEEF)});
        @(negedge clock); #1;
        chk("hex_busy", 64'(busy), 64'd0);
        drain();

        // Decimal overflow just past the range
        wr(32'd100000000, 1'b0, 0, c);
        sb.push_back('{due: c + 1, val: m_dash()});
        repeat (3) begin
            @(negedge clock); #1;
            chk("ovf_busy", 64'(busy), 64'd0);
        end
        drain();

        // Largest in-range value, no blanking
        wr(32'd99999999, 1'b0, 0, c);
        sb.push_back('{due: c + BIN_W + 2, val: m_dec(99999999)});
        drain();

        // Zero shows a single digit
        wr(32'd0, 1'b0, 0, c);
        sb.push_back('{due: c + BIN_W + 2, val: m_dec(0)});
        drain();

        // Overflow through bits above BIN_W
        wr(32'h0800_0000, 1'b0, 0, c);
        sb.push_back('{due: c + 1, val: m_dash()});
        drain();

        // Back-to-back decimal writes: last pending write wins
        wr(32'd5, 1'b0, 0, c0);
        sb.push_back('{due: c0 + BIN_W + 2, val: m_dec(5)});
        wr(32'd7, 1'b0, c0 + 3, cx);
        wr(32'd9, 1'b0, c0 + 6, cx);
        sb.push_back('{due: c0 + 2*(BIN_W + 2), val: m_dec(9)});
        drain();

        // Hex write during a conversion waits its turn
        wr(32'd42, 1'b0, 0, c0);
        sb.push_back('{due: c0 + BIN_W + 2, val: m_dec(42)});
        wr(32'hABCD0123, 1'b1, c0 + 2, cx);
        sb.push_back('{due: c0 + BIN_W + 3, val: m_hex(32'hABCD0123)});
        drain();

        // Reset mid-conversion with a parked write: both discarded
        wr(32'd99999999, 1'b0, 0, c0);
        wr(32'h12345678, 1'b1, c0 + 5, cx);
        while (cyc < c0 + 10) begin
            @(posedge clock); #1;
        end
        reset    = 1'b1;
        sb.delete();
        exp_disp = m_dec(0);
        #1;
        chk("midrst_hex", 64'(hex_out), 64'(m_dec(0)));
        chk("midrst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (40) begin
            @(negedge clock); #1;
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        wr(32'h0, 1'b1, 0, c);
        sb.push_back('{due: c + 1, val: m_hex(32'h0)});
        drain();

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
